// File: rtl/mul32_iter.sv
// rtl/mul32_iter.sv - iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
// One partial sum per cycle through a 32-bit group-carry adder; 33 edges from accept to result.

module mul32_gc_adder (
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] gen;
   logic [31:0] prp;
   logic [31:0] carry;
   logic [7:0]  grp_g;
   logic [7:0]  grp_p;
   logic [8:0]  grp_c;

   assign gen = x & y;
   assign prp = x ^ y;

   // 4-bit groups: lookahead between groups, ripple inside each group
   always_comb begin
      grp_g = '0;
      grp_p = '0;
      grp_c = '0;
      carry = '0;
      grp_c[0] = cin;
      for (int k = 0; k < 8; k++) begin
         grp_g[k] = gen[4*k+3]
                  | (prp[4*k+3] & gen[4*k+2])
                  | (prp[4*k+3] & prp[4*k+2] & gen[4*k+1])
                  | (prp[4*k+3] & prp[4*k+2] & prp[4*k+1] & gen[4*k]);
         grp_p[k] = &prp[4*k +: 4];
         grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      end
      for (int k = 0; k < 8; k++) begin
         carry[4*k] = grp_c[k];
         for (int j = 1; j < 4; j++) begin
            carry[4*k+j] = gen[4*k+j-1] | (prp[4*k+j-1] & carry[4*k+j-1]);
         end
      end
   end

   assign sum  = prp ^ carry;
   assign cout = grp_c[8];

endmodule

module mul32_iter #(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   localparam int            CW       = $clog2(ITERS);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

   logic [1:0]    state;
   logic [63:0]   prod;
   logic [31:0]   mcand;
   logic [CW-1:0] cnt;
   logic          neg;
   logic [1:0]    op_q;

   logic          accept;
   logic          a_signed;
   logic          b_signed;
   logic          a_neg;
   logic          b_neg;
   logic [31:0]   a_mag;
   logic [31:0]   b_mag;
   logic [31:0]   add_y;
   logic [31:0]   add_sum;
   logic          add_cout;
   logic [63:0]   prod_fixed;

   assign in_ready = (state == S_IDLE);
   assign accept   = in_valid & (state == S_IDLE);

   // Operand decode only feeds registers on the accept edge, so junk on a/b/op elsewhere is harmless
   assign a_signed = (op == OP_MULH) | (op == OP_MULHSU);
   assign b_signed = (op == OP_MULH);
   assign a_neg    = a_signed & a[31];
   assign b_neg    = b_signed & b[31];
   assign a_mag    = a_neg ? (~a + 32'd1) : a;
   assign b_mag    = b_neg ? (~b + 32'd1) : b;

   assign add_y = prod[0] ? mcand : 32'd0;

   mul32_gc_adder u_adder (
      .x    (prod[63:32]),
      .y    (add_y),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign prod_fixed = neg ? (~prod + 64'd1) : prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         prod      <= '0;
         mcand     <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         op_q      <= '0;
         out_valid <= 1'b0;
         result    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mcand <= a_mag;
                  prod  <= {32'd0, b_mag};
                  neg   <= a_neg ^ b_neg;
                  op_q  <= op;
                  cnt   <= '0;
                  state <= S_ITER;
               end
            end
            S_ITER: begin
               prod <= {add_cout, add_sum, prod[31:1]};
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               prod      <= prod_fixed;
               result    <= (op_q == OP_MUL) ? prod_fixed[31:0] : prod_fixed[63:32];
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul32_iter.sv
// tb/tb_mul32_iter.sv - self-checking bench for mul32_iter
// Vector table plus random ops feed a result scoreboard; hand sequences cover backpressure and reset abort.

module tb_mul32_iter;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [1:0]  op_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int pass_cnt = 0;
   int total_cnt = 0;
   int spurious = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   mul32_iter #(.ITERS(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .op        (op_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic [1:0] mop);
      logic [63:0] ae;
      logic [63:0] be;
      logic [63:0] p;
      ae = (mop == 2'b01 || mop == 2'b10) ? {{32{ma[31]}}, ma} : {32'd0, ma};
      be = (mop == 2'b01) ? {{32{mb[31]}}, mb} : {32'd0, mb};
      p  = ae * be;
      return (mop == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Scoreboard: every output handshake must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            spurious++;
         end else begin
            check("result", {32'd0, result}, {32'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic issue(input logic [31:0] ta, input logic [31:0] tb2, input logic [1:0] top,
                        input logic [31:0] texp);
      wait_ready();
      @(negedge clk);
      a_i = ta;
      b_i = tb2;
      op_i = top;
      in_valid = 1'b1;
      exp_q.push_back(texp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_i = $urandom;
      b_i = $urandom;
      op_i = 2'($urandom);
   endtask

   task automatic wait_out(output int edges);
      edges = 0;
      while (!out_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic [1:0] top,
                         input logic [31:0] texp, input bit chk_lat);
      int edges;
      issue(ta, tb2, top, texp);
      check("in_ready_busy", {63'd0, in_ready}, 64'd0);
      wait_out(edges);
      if (chk_lat) begin
         check("latency", 64'(edges), 64'd33);
         check("in_ready_done", {63'd0, in_ready}, 64'd0);
      end else begin
         check("out_valid_seen", {63'd0, out_valid}, 64'd1);
      end
      @(posedge clk);
      #1;
      check("out_valid_drop", {63'd0, out_valid}, 64'd0);
      check("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      int edges;
      int ov_seen;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rop;

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a_i = '0;
      b_i = '0;
      op_i = '0;

      vecs.push_back('{32'h00000007, 32'h00000006, 2'b00, 32'h0000002A});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h00000000});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF});
      vecs.push_back('{32'h80000000, 32'h80000000, 2'b01, 32'h40000000});
      vecs.push_back('{32'h80000000, 32'h00000001, 2'b01, 32'hFFFFFFFF});
      vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 2'b10, 32'h80000000});
      vecs.push_back('{32'h80000000, 32'h80000000, 2'b11, 32'h40000000});
      vecs.push_back('{32'h0000FFFF, 32'h0000FFFF, 2'b00, 32'hFFFE0001});
      vecs.push_back('{32'h00010000, 32'h00010000, 2'b11, 32'h00000001});
      vecs.push_back('{32'hFFFFFFFD, 32'h00000005, 2'b01, 32'hFFFFFFFF});
      vecs.push_back('{32'hFFFFFFFD, 32'h00000005, 2'b00, 32'hFFFFFFF1});
      vecs.push_back('{32'h00000000, 32'hFFFFFFFF, 2'b01, 32'h00000000});
      vecs.push_back('{32'h00000002, 32'h80000000, 2'b10, 32'h00000001});

      @(posedge clk);
      #1;
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_result", {32'd0, result}, 64'd0);
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, i == 0);
      end

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         rop = 2'($urandom_range(0, 3));
         run_op(ra, rb, rop, model(ra, rb, rop), 1'b0);
      end

      // Backpressure: result held, pulsed in_valid ignored while DONE
      out_ready = 1'b0;
      issue(32'h00001234, 32'h00000010, 2'b00, 32'h00012340);
      wait_out(edges);
      check("bp_latency", 64'(edges), 64'd33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a_i = 32'h00000003;
         b_i = 32'h00000003;
         op_i = 2'b00;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check("bp_out_valid", {63'd0, out_valid}, 64'd1);
         check("bp_result", {32'd0, result}, 64'h12340);
         check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", {63'd0, out_valid}, 64'd0);
      check("bp_release_ready", {63'd0, in_ready}, 64'd1);
      check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset abort at cnt==10
      check("pre_reset_result", {32'd0, result}, 64'h12340);
      issue(32'h00001111, 32'h00002222, 2'b00, 32'h02468642);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_result", {32'd0, result}, 64'd0);
      check("abort_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
      ov_seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) ov_seen++;
      end
      check("abort_no_result", 64'(ov_seen), 64'd0);

      run_op(32'h00000007, 32'h00000006, 2'b00, 32'h0000002A, 1'b1);

      repeat (2) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("no_spurious", 64'(spurious), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
